// File: rtl/mom_tile_scheduler_if.sv
// mom_tile_scheduler_if: request, result-tag and frame-status signals of the tile scheduler
//   start/busy/done/err           frame control and status
//   req_valid/req_ready/req_*     tile request handshake to the pixel fetcher
//   dp_valid                      datapath result strobe, one per issued tile
//   out_valid/out_row/out_col     output coordinates for the current result
interface mom_tile_scheduler_if #(
  parameter int ROW_W = 9,
  parameter int COL_W = 10
);
  logic start;
  logic busy;
  logic done;
  logic err;
  logic req_valid;
  logic req_ready;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic dp_valid;
  logic out_valid;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  modport master (
    input  start, req_ready, dp_valid,
    output busy, done, err, req_valid, req_row, req_col, out_valid, out_row, out_col
  );
  modport slave (
    output start, req_ready, dp_valid,
    input  busy, done, err, req_valid, req_row, req_col, out_valid, out_row, out_col
  );
endinterface

// File: rtl/mom_tile_scheduler.sv
// mom_tile_scheduler: walks the frame in 5x14 tiles, issues tile coordinates and tags returned results
//   clk, rst  clock and synchronous active-high reset
//   bus       mom_tile_scheduler_if master: start/busy/done/err, req_* handshake, dp_valid, out_*
module mom_tile_scheduler #(
  parameter int IMG_W = 638,
  parameter int IMG_H = 482,
  parameter int DEPTH = 4,
  parameter int ROW_W = 9,
  parameter int COL_W = 10
) (
  input logic clk,
  input logic rst,
  mom_tile_scheduler_if.master bus
);
  localparam int TPB = (IMG_W - 2) / 12;
  localparam int BANDS = (IMG_H - 2) / 3;
  localparam int TOTAL = BANDS * TPB;
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [AW:0] cnt;
  logic [AW-1:0] wp, rp;
  logic [13:0] issued, retired;
  logic [ROW_W-1:0] tag_row [DEPTH];
  logic [COL_W-1:0] tag_col [DEPTH];
  logic xfer, pop, last_pop, go, wrap;
  assign bus.req_valid = state == ISSUE && cnt < (AW+1)'(DEPTH);
  assign bus.req_row = row;
  assign bus.req_col = col;
  assign bus.busy = state != IDLE;
  assign xfer = bus.req_valid & bus.req_ready;
  assign pop = bus.dp_valid && cnt != '0;
  assign last_pop = pop && state == DRAIN && retired == 14'(TOTAL - 1);
  assign go = state == IDLE && bus.start;
  assign wrap = col == COL_W'(13);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      issued <= '0;
      retired <= '0;
      bus.out_valid <= 1'b0;
      bus.out_row <= '0;
      bus.out_col <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.out_valid <= pop;
      bus.done <= last_pop;
      cnt <= cnt + (AW+1)'(xfer) - (AW+1)'(pop);
      if (pop) begin
        bus.out_row <= tag_row[rp];
        bus.out_col <= tag_col[rp];
        rp <= rp + 1'b1;
        retired <= retired + 14'd1;
      end
      if (xfer) begin
        wp <= wp + 1'b1;
        issued <= issued + 14'd1;
        row <= wrap ? row + ROW_W'(3) : row;
        col <= wrap ? COL_W'(IMG_W - 1) : col - COL_W'(12);
      end
      if (go) begin
        state <= ISSUE;
        row <= '0;
        col <= COL_W'(IMG_W - 1);
        cnt <= '0;
        wp <= '0;
        rp <= '0;
        issued <= '0;
        retired <= '0;
        bus.err <= 1'b0;
      end else begin
        bus.err <= bus.err | (bus.dp_valid && cnt == '0);
        if (xfer && issued == 14'(TOTAL - 1)) state <= DRAIN;
        if (last_pop) state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && xfer) begin
      tag_row[wp] <= row;
      tag_col[wp] <= col - COL_W'(2);
    end
  end
endmodule

// File: tb/tb_mom_tile_scheduler.sv
// tb_mom_tile_scheduler: scoreboard bench for the tile scheduler at default and small frame sizes
module tb_mom_tile_scheduler;
  localparam int W = 638;
  localparam int H = 482;
  localparam int TPB = (W - 2) / 12;
  localparam int BANDS = (H - 2) / 3;
  localparam int TOTAL = TPB * BANDS;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int req_idx = 0;
  int ret_cnt = 0;
  int done_cnt = 0;
  int tq_row[$];
  int tq_col[$];
  logic hold = 1'b0;
  int hold_row, hold_col, er, ec;
  always #5 clk = ~clk;
  mom_tile_scheduler_if #(.ROW_W(9), .COL_W(10)) bus();
  mom_tile_scheduler_if #(.ROW_W(9), .COL_W(10)) sbus();
  mom_tile_scheduler #(.IMG_W(W), .IMG_H(H), .DEPTH(4), .ROW_W(9), .COL_W(10)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  mom_tile_scheduler #(.IMG_W(26), .IMG_H(8), .DEPTH(4), .ROW_W(9), .COL_W(10)) sdut (
    .clk(clk), .rst(rst), .bus(sbus)
  );
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  function automatic int exp_row(input int k);
    return 3 * (k / TPB);
  endfunction
  function automatic int exp_col(input int k);
    return W - 1 - 12 * (k % TPB);
  endfunction
  function automatic longint all_out();
    return {bus.req_valid, bus.req_row, bus.req_col, bus.out_valid, bus.out_row, bus.out_col,
            bus.busy, bus.done, bus.err};
  endfunction
  always @(negedge clk) begin
    #2;
    if (bus.out_valid) begin
      if (tq_row.size() == 0) chk("out_without_tile", 1, 0);
      else begin
        er = tq_row.pop_front();
        ec = tq_col.pop_front();
        ret_cnt++;
        chk("out_row", bus.out_row, er);
        chk("out_col", bus.out_col, ec);
        chk("done_on_last_out", bus.done, ret_cnt == TOTAL);
      end
    end else if (bus.done) chk("done_without_out", 1, 0);
    if (bus.done) done_cnt++;
    if (hold && bus.req_valid) begin
      chk("req_row_stable", bus.req_row, hold_row);
      chk("req_col_stable", bus.req_col, hold_col);
    end
    hold = bus.req_valid && !bus.req_ready && !rst;
    hold_row = bus.req_row;
    hold_col = bus.req_col;
    if (bus.req_valid && bus.req_ready && !rst) begin
      chk("req_row", bus.req_row, exp_row(req_idx));
      chk("req_col", bus.req_col, exp_col(req_idx));
      tq_row.push_back(exp_row(req_idx));
      tq_col.push_back(exp_col(req_idx) - 2);
      req_idx++;
    end
    if (rst || (bus.start && !bus.busy)) begin
      tq_row.delete();
      tq_col.delete();
      req_idx = 0;
      ret_cnt = 0;
      hold = 1'b0;
    end
  end
  task automatic run_frame(input int mode, input int budget, input int stop_after, output int n);
    logic [2:0] pipe;
    int c, d0;
    pipe = '0;
    c = 0;
    n = 0;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (done_cnt == d0 && c < budget && (stop_after == 0 || n < stop_after)) begin
      bus.req_ready = mode == 0 || c % 3 == 0;
      bus.dp_valid = pipe[2];
      #1;
      pipe = {pipe[1:0], bus.req_valid & bus.req_ready};
      n += int'(bus.req_valid & bus.req_ready);
      c++;
      @(negedge clk);
    end
    bus.req_ready = 1'b0;
    bus.dp_valid = 1'b0;
    if (stop_after == 0) chk("frame_within_budget", c < budget, 1);
  endtask
  initial begin
    int n, d0, k, sdone;
    int srow[8];
    int scol[8];
    int erow[4] = '{0, 0, 3, 3};
    int ecol[4] = '{25, 13, 25, 13};
    logic [2:0] spipe;
    bus.start = 1'b0;
    bus.req_ready = 1'b0;
    bus.dp_valid = 1'b0;
    sbus.start = 1'b0;
    sbus.req_ready = 1'b0;
    sbus.dp_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_out(), 0);
    chk("reset_small_busy", sbus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    bus.dp_valid = 1'b1;
    @(negedge clk);
    bus.dp_valid = 1'b0;
    #1;
    chk("spurious_err", bus.err, 1);
    chk("spurious_out_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("start_clears_err", bus.err, 0);
    chk("start_req_valid", bus.req_valid, 1);
    chk("start_req_row", bus.req_row, 0);
    chk("start_req_col", bus.req_col, W - 1);
    chk("start_busy", bus.busy, 1);
    bus.req_ready = 1'b1;
    n = 0;
    repeat (8) begin
      #1;
      n += int'(bus.req_valid & bus.req_ready);
      @(negedge clk);
    end
    chk("credit_transfers", n, 4);
    chk("credit_req_valid_low", bus.req_valid, 0);
    bus.dp_valid = 1'b1;
    @(negedge clk);
    bus.dp_valid = 1'b0;
    #1;
    chk("credit_req_valid_back", bus.req_valid, 1);
    chk("credit_out_valid", bus.out_valid, 1);
    chk("credit_out_row", bus.out_row, 0);
    chk("credit_out_col", bus.out_col, W - 3);
    @(negedge clk);
    bus.req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_after_credit", all_out(), 0);
    rst = 1'b0;
    d0 = done_cnt;
    run_frame(0, 10000, 0, n);
    chk("full_requests", n, TOTAL);
    chk("full_scoreboard_count", req_idx, TOTAL);
    chk("full_done_pulses", done_cnt - d0, 1);
    chk("full_tags_drained", tq_row.size(), 0);
    chk("full_busy_low", bus.busy, 0);
    chk("full_err_low", bus.err, 0);
    d0 = done_cnt;
    run_frame(1, 30000, 0, n);
    chk("bp_requests", n, TOTAL);
    chk("bp_done_pulses", done_cnt - d0, 1);
    chk("bp_busy_low", bus.busy, 0);
    d0 = done_cnt;
    run_frame(0, 10000, 100, n);
    chk("mid_transfers", n, 100);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_reset_outputs", all_out(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("restart_req_valid", bus.req_valid, 1);
    chk("restart_req_row", bus.req_row, 0);
    chk("restart_req_col", bus.req_col, W - 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sbus.req_ready = 1'b1;
    sbus.start = 1'b1;
    @(negedge clk);
    spipe = '0;
    k = 0;
    sdone = 0;
    for (int c = 0; c < 30; c++) begin
      sbus.start = c == 2;
      sbus.dp_valid = spipe[2];
      #1;
      if (sbus.req_valid && sbus.req_ready && k < 8) begin
        srow[k] = int'(sbus.req_row);
        scol[k] = int'(sbus.req_col);
      end
      k += int'(sbus.req_valid & sbus.req_ready);
      sdone += int'(sbus.done);
      spipe = {spipe[1:0], sbus.req_valid & sbus.req_ready};
      @(negedge clk);
    end
    sbus.start = 1'b0;
    sbus.dp_valid = 1'b0;
    chk("small_requests", k, 4);
    for (int i = 0; i < 4; i++) begin
      chk("small_req_row", srow[i], erow[i]);
      chk("small_req_col", scol[i], ecol[i]);
    end
    chk("small_done_pulses", sdone, 1);
    chk("small_busy_low", sbus.busy, 0);
    chk("small_err_low", sbus.err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
